// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Byte/halfword/word load-store unit sitting between a core request
//             port and a single-port, combinational-read data memory. Sub-word
//             stores use a read-modify-write sequence. Misaligned, illegal-size
//             and out-of-range accesses return an error without touching memory.
//  Ports    :
//    clk, rst               clock and synchronous active-high reset
//    req_valid/req_ready    request handshake (ready only when idle)
//    req_we, req_size,      request attributes: store flag, size (00 B,
//    req_signed, req_addr,  01 H, 10 W, 11 illegal), sign-extend, byte
//    req_wdata              address, right-justified store data
//    resp_valid/rdata/err   one-cycle completion with load data / error flag
//    mem_WE/A/WD, mem_RD    data memory write enable, word index, write data,
//                           combinational read data
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STORE_W = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_err;
    logic [31:0] lat_rdata;
    logic [31:0] lat_merged;

    logic        accept;
    logic        req_err;
    logic [31:0] lat_index;
    logic [31:0] load_lane;
    logic [31:0] merged_word;

    // Pick the addressed lane out of a memory word and extend it.
    function automatic logic [31:0] extract_lane(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: extract_lane = {{24{sgn & b[7]}}, b};
            SIZE_HALF: extract_lane = {{16{sgn & h[15]}}, h};
            default:   extract_lane = word;
        endcase
    endfunction

    // Replace only the addressed lane(s) of a word with the low store bits.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SIZE_BYTE: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                data = {2{wdata[15:0]}};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        merge_lane = (word & ~mask) | (data & mask);
    endfunction

    assign accept = req_valid && (state == IDLE);

    assign req_err = (req_size == 2'b11)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                   || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    assign lat_index   = {2'b00, lat_addr[31:2]};
    assign load_lane   = extract_lane(mem_RD, lat_size, lat_addr[1:0], lat_signed);
    assign merged_word = merge_lane(mem_RD, lat_wdata, lat_size, lat_addr[1:0]);

    // ------------------------------------------------------------------
    // State register and latched request fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_err    <= 1'b0;
            lat_rdata  <= 32'h0;
            lat_merged <= 32'h0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_we     <= req_we;
                lat_size   <= req_size;
                lat_signed <= req_signed;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_err    <= req_err;
                lat_rdata  <= 32'h0;
            end
            if (state == LOAD) begin
                lat_rdata <= load_lane;
            end
            if (state == RMW_RD) begin
                lat_merged <= merged_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_WE     = 1'b0;
        mem_A      = 32'h0;
        mem_WD     = 32'h0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (!req_we) begin
                        next_state = LOAD;
                    end else if (req_size == SIZE_WORD) begin
                        next_state = STORE_W;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_A      = lat_index;
                next_state = RESP;
            end
            STORE_W: begin
                mem_A      = lat_index;
                mem_WE     = 1'b1;
                mem_WD     = lat_wdata;
                next_state = RESP;
            end
            RMW_RD: begin
                mem_A      = lat_index;
                next_state = RMW_WR;
            end
            RMW_WR: begin
                mem_A      = lat_index;
                mem_WE     = 1'b1;
                mem_WD     = lat_merged;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = lat_err;
                // Stores and errors report zero data.
                resp_rdata = (lat_we || lat_err) ? 32'h0 : lat_rdata;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // A write must never escape while reset is held.
        if (rst) begin
            mem_WE = 1'b0;
        end
    end

endmodule
`default_nettype wire
